// File: rtl/pcie_dll_rx_acknak_pkg.sv
// Shared definitions for the PCIe Data Link Layer receive Ack/Nak block.
//   PCIe_SEQ_W / PCIe_LCRC_W : sequence-number and LCRC field widths
//   DLLP_ACK / DLLP_NAK      : DLLP type encodings driven on dllp_type_o
//   rx_state_t               : receive sequencing state (NORMAL / NAK_SCHEDULED)
package pcie_dll_rx_acknak_pkg;

  localparam int unsigned PCIe_SEQ_W  = 12;
  localparam int unsigned PCIe_LCRC_W = 32;

  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;

  typedef enum logic {
    NORMAL,
    NAK_SCHEDULED
  } rx_state_t;

endpackage

// File: rtl/crc32_checker.sv
// Combinational LCRC check.
// CRC-32 (poly 32'h04C11DB7, init all-ones, MSB-first, result inverted)
// computed over data and compared against crc.
//   data   : protected bits, MSB processed first
//   crc    : received LCRC
//   crc_ok : high when the computed LCRC equals crc
module crc32_checker #(
  parameter int unsigned DATA_W = 268
) (
  input  logic [DATA_W-1:0] data,
  input  logic [31:0]       crc,
  output logic              crc_ok
);

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] crc_calc;

  always_comb begin
    crc_calc = '1;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      crc_calc = {crc_calc[30:0], 1'b0}
               ^ ({32{crc_calc[31] ^ data[DATA_W-1-i]}} & POLY);
    end
    crc_ok = (~crc_calc == crc);
  end

endmodule

// File: rtl/pcie_dll_rx_fifo.sv
// Synchronous receive FIFO with registered storage and occupancy count.
// Data written at cycle t is visible on rd_data/rd_valid at t+1.
//   push/wr_data     : write request (ignored while full)
//   pop              : consumer accepts head (ignored while empty)
//   rd_valid/rd_data : head entry
//   full             : no free entries
//   count            : current occupancy, 0..DEPTH
module pcie_dll_rx_fifo #(
  parameter  int unsigned WIDTH = 256,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && rd_valid;

  // Storage is reset so the head reads zero after reset or a mid-stream flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_dll_rx_acknak.sv
// PCIe Data Link Layer receive path: LCRC + sequence check, receive FIFO
// toward the Transaction Layer, Ack/Nak DLLP generation and credit report.
// Build option: PCIE_DLL_RX_ACK_COALESCE_EN enables Ack coalescing
// (ACK_COALESCE good TLPs or ACK_TIMEOUT cycles); otherwise every in-order
// good TLP requests an Ack.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   tlp_valid_i/tlp_i/tlp_ready_o   : PHY side {seq, tlp, lcrc}
//   tlp_valid_o/tlp_o/tlp_ready_i   : Transaction Layer side (FIFO head)
//   dllp_valid_o/type/seq/ready_i   : Ack/Nak DLLP output slot
//   fc_credit_o                     : free FIFO entries
//   nak_sched_o                     : NAK_SCHEDULED state indicator
module pcie_dll_rx_acknak
  import pcie_dll_rx_acknak_pkg::*;
#(
  parameter int unsigned TLP_W        = 256,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ACK_COALESCE = 4,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     tlp_valid_i,
  input  logic [PCIe_SEQ_W+TLP_W+PCIe_LCRC_W-1:0]  tlp_i,
  output logic                                     tlp_ready_o,
  output logic                                     tlp_valid_o,
  output logic [TLP_W-1:0]                         tlp_o,
  input  logic                                     tlp_ready_i,
  output logic                                     dllp_valid_o,
  output logic [7:0]                               dllp_type_o,
  output logic [PCIe_SEQ_W-1:0]                    dllp_seq_o,
  input  logic                                     dllp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]               fc_credit_o,
  output logic                                     nak_sched_o
);

  localparam int unsigned IN_W  = PCIe_SEQ_W + TLP_W + PCIe_LCRC_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
      ACK_COALESCE < 1 || ACK_COALESCE > 15 ||
      ACK_TIMEOUT < 2 || ACK_TIMEOUT > 1023) begin : g_bad_param
    $error("pcie_dll_rx_acknak: parameter out of range");
  end

  logic [PCIe_SEQ_W-1:0] rx_seq;
  logic [TLP_W-1:0]      rx_tlp;
  logic                  crc_ok;

  assign rx_seq = tlp_i[IN_W-1 -: PCIe_SEQ_W];
  assign rx_tlp = tlp_i[PCIe_LCRC_W +: TLP_W];

  crc32_checker #(
    .DATA_W (PCIe_SEQ_W + TLP_W)
  ) u_crc (
    .data   (tlp_i[IN_W-1:PCIe_LCRC_W]),
    .crc    (tlp_i[PCIe_LCRC_W-1:0]),
    .crc_ok (crc_ok)
  );

  rx_state_t             state_q, state_d;
  logic [PCIe_SEQ_W-1:0] expected_q, expected_d;
  logic [PCIe_SEQ_W-1:0] seq_diff;
  logic                  nak_pend_q, ack_pend_q;
  logic                  xfer, good_inorder, dup, nak_ev;
  logic                  nak_set, ack_set;
  logic                  eff_nak, eff_ack;
  logic                  slot_free, load;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;

`ifdef PCIE_DLL_RX_ACK_COALESCE_EN
  logic [3:0] ack_cnt_q, ack_cnt_d;
  logic [9:0] timer_q, timer_d;
`endif

  // Classification: modular distance splits duplicates (upper half) from
  // lost-TLP gaps (lower half, non-zero).
  always_comb begin
    seq_diff     = rx_seq - expected_q;
    xfer         = tlp_valid_i && tlp_ready_o;
    good_inorder = xfer && crc_ok && (seq_diff == '0);
    dup          = xfer && crc_ok && seq_diff[PCIe_SEQ_W-1];
    nak_ev       = xfer && !good_inorder && !dup;
    expected_d   = good_inorder ? expected_q + 1'b1 : expected_q;
  end

  always_comb begin
    state_d = state_q;
    nak_set = 1'b0;
    case (state_q)
      NORMAL: begin
        if (nak_ev) begin
          state_d = NAK_SCHEDULED;
          nak_set = 1'b1;
        end
      end
      NAK_SCHEDULED: begin
        if (good_inorder) begin
          state_d = NORMAL;
        end
      end
    endcase
  end

  // Events are folded into the load decision in the same cycle so that an
  // event with the slot free is visible on dllp_valid_o one cycle later, and
  // the loaded seq already accounts for the TLP accepted this cycle.
  always_comb begin
`ifdef PCIE_DLL_RX_ACK_COALESCE_EN
    ack_cnt_d = (good_inorder && ack_cnt_q != 4'hF) ? ack_cnt_q + 1'b1 : ack_cnt_q;
    ack_set   = dup
             || (ack_cnt_d >= 4'(ACK_COALESCE))
             || ((ack_cnt_q != '0) && (timer_q == 10'(ACK_TIMEOUT)));
`else
    ack_set   = good_inorder || dup;
`endif
    eff_nak   = nak_pend_q || nak_set;
    eff_ack   = ack_pend_q || ack_set;
    slot_free = !dllp_valid_o || dllp_ready_i;
    load      = slot_free && (eff_nak || eff_ack);
`ifdef PCIE_DLL_RX_ACK_COALESCE_EN
    if (load) begin
      timer_d = '0;
    end else if ((ack_cnt_q != '0) && (timer_q != 10'(ACK_TIMEOUT))) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NORMAL;
      expected_q   <= '0;
      nak_pend_q   <= 1'b0;
      ack_pend_q   <= 1'b0;
      dllp_valid_o <= 1'b0;
      dllp_type_o  <= DLLP_ACK;
      dllp_seq_o   <= '1;
`ifdef PCIE_DLL_RX_ACK_COALESCE_EN
      ack_cnt_q    <= '0;
      timer_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      // A loaded Nak implies the Ack, so any load clears the Ack state.
      nak_pend_q <= eff_nak && !load;
      ack_pend_q <= eff_ack && !load;
      if (slot_free) begin
        dllp_valid_o <= load;
      end
      if (load) begin
        dllp_type_o <= eff_nak ? DLLP_NAK : DLLP_ACK;
        dllp_seq_o  <= expected_d - 1'b1;
      end
`ifdef PCIE_DLL_RX_ACK_COALESCE_EN
      ack_cnt_q <= load ? '0 : ack_cnt_d;
      timer_q   <= timer_d;
`endif
    end
  end

  pcie_dll_rx_fifo #(
    .WIDTH (TLP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (good_inorder),
    .wr_data  (rx_tlp),
    .pop      (tlp_ready_i),
    .rd_valid (tlp_valid_o),
    .rd_data  (tlp_o),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign tlp_ready_o = !fifo_full;
  assign fc_credit_o = CNT_W'(DEPTH) - fifo_count;
  assign nak_sched_o = (state_q == NAK_SCHEDULED);

endmodule
